// File: rtl/commit_rob.sv
// commit_rob: in-order commit reorder buffer with squash; COMMIT_ROB_BYPASS_EN enables direct head bypass
module commit_rob #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      complete_val,
  output logic                      complete_rdy,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  output logic                      commit_val,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [31:0]               commit_pc,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen,
  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num
);
  localparam int n = 2 ** p_seq_num_bits;
  typedef logic [p_seq_num_bits-1:0] seq_t;
  logic [n-1:0] valid, valid_nxt, kill, wen_mem;
  logic [31:0] pc_mem [n];
  logic [4:0] waddr_mem [n];
  logic [31:0] wdata_mem [n];
  seq_t head_ptr;
  logic fire, drop, wr, byp, head_hit, adv, store;
  function automatic logic younger(seq_t s, seq_t i, seq_t h);
    return seq_t'(i - h) > seq_t'(s - h);
  endfunction
  assign complete_rdy = !rst;
  assign fire = complete_val && complete_rdy;
  assign drop = squash_val && younger(squash_seq_num, complete_seq_num, head_ptr);
  assign wr = fire && !drop;
`ifdef COMMIT_ROB_BYPASS_EN
  assign byp = wr && complete_seq_num == head_ptr && !valid[head_ptr];
`else
  assign byp = 1'b0;
`endif
  assign head_hit = !byp && valid[head_ptr];
  assign adv = byp || head_hit;
  assign store = wr && !byp;
  for (genvar i = 0; i < n; i++) begin : g_kill
    assign kill[i] = squash_val && younger(squash_seq_num, seq_t'(i), head_ptr);
  end
  // head is never younger than the squasher, so its clear and the kill mask never conflict
  always_comb begin
    valid_nxt = valid & ~kill;
    if (head_hit) valid_nxt[head_ptr] = 1'b0;
    if (store) valid_nxt[complete_seq_num] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid          <= '0;
      head_ptr       <= '0;
      commit_val     <= 1'b0;
      commit_seq_num <= '0;
      commit_pc      <= '0;
      commit_waddr   <= '0;
      commit_wdata   <= '0;
      commit_wen     <= 1'b0;
    end else begin
      valid      <= valid_nxt;
      commit_val <= adv;
      if (adv) begin
        head_ptr       <= head_ptr + 1'b1;
        commit_seq_num <= head_ptr;
        commit_pc      <= byp ? complete_pc : pc_mem[head_ptr];
        commit_waddr   <= byp ? complete_waddr : waddr_mem[head_ptr];
        commit_wdata   <= byp ? complete_wdata : wdata_mem[head_ptr];
        commit_wen     <= byp ? complete_wen : wen_mem[head_ptr];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[complete_seq_num]    <= complete_pc;
      waddr_mem[complete_seq_num] <= complete_waddr;
      wdata_mem[complete_seq_num] <= complete_wdata;
      wen_mem[complete_seq_num]   <= complete_wen;
    end
  end
  a_no_dup_complete: assert property (@(posedge clk) disable iff (rst) !(wr && valid[complete_seq_num]));
endmodule

// File: tb/tb_commit_rob.sv
// tb_commit_rob: table vectors, directed corner sequences and a randomized run against an unwrapped-sequence model
module tb_commit_rob;
  localparam int nb = 5;
`ifdef COMMIT_ROB_BYPASS_EN
  localparam bit byp_en = 1'b1;
`else
  localparam bit byp_en = 1'b0;
`endif
  typedef struct packed {logic [31:0] pc; logic [4:0] waddr; logic [31:0] wdata; logic wen;} pl_t;
  typedef struct {bit cv; int seq; int exp_nb; int exp_b;} vec_t;
  logic clk = 1'b0, rst;
  logic complete_val, complete_rdy, complete_wen, commit_val, commit_wen, squash_val;
  logic [nb-1:0] complete_seq_num, commit_seq_num, squash_seq_num;
  logic [31:0] complete_pc, complete_wdata, commit_pc, commit_wdata;
  logic [4:0] complete_waddr, commit_waddr;
  int n_checks = 0, n_pass = 0;
  always #5 clk = ~clk;
  commit_rob #(.p_seq_num_bits(nb)) dut (
    .clk(clk), .rst(rst),
    .complete_val(complete_val), .complete_rdy(complete_rdy), .complete_seq_num(complete_seq_num),
    .complete_pc(complete_pc), .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
    .complete_wen(complete_wen),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num), .commit_pc(commit_pc),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num)
  );
  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [31:0] pc_of(int s);
    return 32'h1000 + 32'(s) * 16;
  endfunction
  function automatic pl_t mk(logic [31:0] pc);
    return '{pc: pc, waddr: pc[6:2], wdata: ~pc, wen: pc[2]};
  endfunction
  task automatic drive(bit cv, int seq, pl_t p, bit sv, int sseq);
    complete_val = cv;
    complete_seq_num = seq[nb-1:0];
    complete_pc = p.pc;
    complete_waddr = p.waddr;
    complete_wdata = p.wdata;
    complete_wen = p.wen;
    squash_val = sv;
    squash_seq_num = sseq[nb-1:0];
  endtask
  task automatic idle();
    drive(0, 0, '0, 0, 0);
  endtask
  task automatic cyc(bit cv, int seq, logic [31:0] pc, bit sv, int sseq);
    drive(cv, seq, mk(pc), sv, sseq);
    @(negedge clk);
    idle();
  endtask
  task automatic wait_commit(string name, int seq, logic [31:0] pc, int budget);
    for (int k = 0; k < budget && !commit_val; k++) @(negedge clk);
    chk(name, {commit_val, commit_seq_num, commit_pc}, {1'b1, nb'(seq), pc});
    @(negedge clk);
  endtask
  task automatic quiet(string name, int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk(name, commit_val, 0);
      @(negedge clk);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask
  // model keeps unwrapped sequence numbers, so "younger" is plain integer comparison
  pl_t done[int];
  int h, eseq;
  bit ev;
  pl_t epl;
  task automatic model_step(bit r, bit cv, int ca, pl_t p, bit sv, int sa);
    bit w;
    int ks[$];
    if (r) begin
      done.delete();
      h = 0; ev = 0; eseq = 0; epl = '0;
      return;
    end
    w = cv && !(sv && ca > sa);
    if (byp_en && w && ca == h && !done.exists(h)) begin
      ev = 1; eseq = h; epl = p; h++; w = 0;
    end else if (done.exists(h)) begin
      ev = 1; eseq = h; epl = done[h]; done.delete(h); h++;
    end else ev = 0;
    if (sv) begin
      foreach (done[k]) if (k > sa) ks.push_back(k);
      foreach (ks[j]) done.delete(ks[j]);
    end
    if (w) done[ca] = p;
  endtask
  vec_t tbl[14];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int got, e;
    tbl = '{'{1,0,-1,-1}, '{1,1,-1,0}, '{1,2,0,1}, '{0,0,1,2}, '{0,0,2,-1}, '{0,0,-1,-1},
            '{1,5,-1,-1}, '{1,4,-1,-1}, '{1,3,-1,-1}, '{0,0,-1,3}, '{0,0,3,4}, '{0,0,4,5},
            '{0,0,5,-1}, '{0,0,-1,-1}};
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen}, 0);
    chk("reset_rdy", complete_rdy, 0);
    rst = 1'b0;
    #1 chk("rdy_after_reset", complete_rdy, 1);
    @(negedge clk);
    // in-order then out-of-order completion
    foreach (tbl[k]) begin
      e = byp_en ? tbl[k].exp_b : tbl[k].exp_nb;
      chk("tbl_val", commit_val, e >= 0);
      if (e >= 0) chk("tbl_seq_pc", {commit_seq_num, commit_pc}, {nb'(e), pc_of(e)});
      drive(tbl[k].cv, tbl[k].seq, mk(pc_of(tbl[k].seq)), 0, 0);
      @(negedge clk);
    end
    idle();
    // squash of buffered younger entries
    do_reset();
    cyc(1, 1, pc_of(1), 0, 0);
    cyc(1, 2, pc_of(2), 0, 0);
    cyc(1, 3, pc_of(3), 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, pc_of(0), 0, 0);
    wait_commit("sq_c0", 0, pc_of(0), 4);
    wait_commit("sq_c1", 1, pc_of(1), 0);
    quiet("sq_no_younger", 5);
    cyc(1, 2, 32'h200, 0, 0);
    wait_commit("sq_new2", 2, 32'h200, 4);
    // squash in the same cycle as a younger completion
    cyc(1, 3, pc_of(3), 0, 0);
    wait_commit("ss_c3", 3, pc_of(3), 4);
    cyc(1, 6, pc_of(6), 1, 4);
    quiet("ss_no6", 5);
    cyc(1, 4, pc_of(4), 0, 0);
    wait_commit("ss_c4", 4, pc_of(4), 4);
    cyc(1, 5, pc_of(5), 0, 0);
    wait_commit("ss_c5", 5, pc_of(5), 4);
    quiet("ss_no6_late", 4);
    // wrap-around
    do_reset();
    got = 0;
    for (int t = 0; t < 60 && (t < 40 || got < 40); t++) begin
      if (got > 0 && got < 40) chk("wrap_contig", commit_val, 1);
      if (commit_val) begin
        chk("wrap_seq_pc", {commit_seq_num, commit_pc}, {nb'(got), pc_of(got)});
        got++;
      end
      if (t < 40) drive(1, t % 32, mk(pc_of(t)), 0, 0);
      else idle();
      @(negedge clk);
    end
    chk("wrap_count", got, 40);
    cyc(1, 8, pc_of(99), 0, 0);
    wait_commit("wrap_head8", 8, pc_of(99), 4);
    // reset mid-operation, without a clean reset first
    cyc(1, 1, pc_of(1), 0, 0);
    cyc(1, 2, pc_of(2), 0, 0);
    cyc(1, 3, pc_of(3), 0, 0);
    rst = 1'b1;
    #1 chk("midrst_rdy", complete_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", {commit_val, commit_seq_num, commit_pc}, 0);
    cyc(1, 0, pc_of(0), 0, 0);
    wait_commit("midrst_c0", 0, pc_of(0), 4);
    quiet("midrst_none", 6);
    // randomized run against the model
    do_reset();
    model_step(1, 0, 0, '0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit r, cv, sv;
      int ca, sa;
      pl_t p;
      chk("rnd_commit",
          commit_val ? {1'b1, commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen} : 76'b0,
          ev ? {1'b1, nb'(eseq), epl} : 76'b0);
      r = $urandom_range(0, 299) == 0;
      ca = h + (($urandom % 4 == 0) ? $urandom_range(0, 30) : $urandom_range(0, 5));
      cv = ($urandom % 4 != 0) && !done.exists(ca);
      sv = $urandom % 12 == 0;
      sa = h + $urandom_range(0, 10);
      p = {$urandom, 5'($urandom), $urandom, 1'($urandom)};
      drive(cv, ca, p, sv, sa);
      rst = r;
      model_step(r, cv, ca, p, sv, sa);
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/commit_rob.md
# commit_rob

In-order commit stage for the BLIMP pipeline. Accepts out-of-order completion of instructions tagged with sequence numbers and buffers them in a reorder array indexed by sequence number. Broadcasts each one, strictly in sequence-number order, as a commit notification to the sequence-number generator and other commit subscribers. Also subscribes to squash notifications and discards buffered or arriving completions younger than the squashing instruction.

## Interface
- p_seq_num_bits, 5, sequence-number width; reorder array holds 2**p_seq_num_bits entries.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- complete_val  in  1  completion valid.
- complete_rdy  out  1  completion ready.
- complete_seq_num  in  p_seq_num_bits  sequence number of the completing instruction.
- complete_pc  in  32  PC.
- complete_waddr  in  5  destination register.
- complete_wdata  in  32  writeback data.
- complete_wen  in  1  writeback enable.
- commit_val  out  1  commit notification valid; drives CommitNotif val.
- commit_seq_num  out  p_seq_num_bits  committed sequence number.
- commit_pc  out  32  committed PC.
- commit_waddr  out  5  committed destination.
- commit_wdata  out  32  committed data.
- commit_wen  out  1  committed writeback enable.
- squash_val  in  1  squash notification valid.
- squash_seq_num  in  p_seq_num_bits  sequence number of the squashing instruction (survives).

## Operation
- State: valid[2**N], payload[2**N] (pc, waddr, wdata, wen), head_ptr (N bits), registered commit outputs.
- complete_rdy = !rst; completion fires on complete_val & complete_rdy and writes payload[seq], sets valid[seq].
- Head check each cycle: if valid[head_ptr], load commit regs from that entry, clear valid[head_ptr], head_ptr <= head_ptr + 1 (mod 2**N). Otherwise commit_val <= 0.
- Younger test, using current head_ptr, all arithmetic mod 2**N: younger(S,i) = (i - head_ptr) > (S - head_ptr).
- On squash_val: clear valid[i] for every i with younger(squash_seq_num, i). The entry at squash_seq_num and all older entries are kept. head_ptr is unaffected.
- Completion in the same cycle as squash:
  - Dropped (not written) if younger(squash_seq_num, complete_seq_num).
  - Otherwise written normally.
- A head commit in the same cycle as a squash always proceeds; head is never younger than the squasher.
- Completion to an entry that is already valid is a protocol error. It is flagged by a non-synthesis assertion; the payload is overwritten.
- No back-pressure on commit: at most one commit per cycle, unconditionally broadcast.

## Timing
- Reset values:
  - head_ptr = 0, all valid = 0.
  - commit_val = 0; commit_seq_num, commit_pc, commit_waddr, commit_wdata, commit_wen = 0.
  - complete_rdy = 0 while rst is high.
- rst asserted mid-operation discards all buffered entries and any pending commit on the next edge.
- Base latency: completion accepted in cycle c → entry visible in c+1 → commit_val high in cycle c+2 if that entry is the head.
- Throughput: one commit per cycle once the head run is contiguous.
- Wrap-around: head_ptr increments 2**N-1 → 0 with no gap. The sequence-number generator guarantees no more than 2**N-1 entries in flight.

## Configuration
- COMMIT_ROB_BYPASS_EN defined: a completion with complete_seq_num == head_ptr, while valid[head_ptr] == 0 and no drop due to squash, loads the commit regs directly without writing the array; head_ptr advances.
  - commit_val is high in c+1.
  - That same cycle the array-based head check is suppressed.
- Not defined: all commits go through the array with 2-cycle latency.

## Test plan
- In-order: complete seq 0,1,2 in cycles 0,1,2 → commit_val high with seq 0,1,2 in cycles 2,3,4 (cycles 1,2,3 with bypass); pc/wdata match the completions.
- Out-of-order: complete 2 (cycle 0), 1 (cycle 1), 0 (cycle 2) → no commit before cycle 4 (cycle 3 with bypass); then 0,1,2 on consecutive cycles.
- Squash: head 0; complete 1,2,3; squash S=1; complete 0 → commits 0,1 only. A later completion of seq 2 with pc 0x200 commits pc 0x200.
- Simultaneous squash and completion: squash S=4 and complete 6 in the same cycle (head 4) → 6 never commits; a following completion of seq 4 commits.
- Wrap: p_seq_num_bits=5; 40 in-order completions → commit_seq_num runs 0..31,0..7 contiguously; head_ptr ends at 8.
- Reset mid-op: entries 1..3 valid, assert rst one cycle → commit_val=0, head_ptr=0; then complete 0 → only seq 0 commits.
